// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the instruction memory load controller.
// Processor-wide widths, FSM encodings and the fetch filler word.
package imem_load_ctrl_pkg;

  localparam int PKG_ADDR_W = 10;
  localparam int PKG_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_DONE = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Loader, fetch, memory and status bundle of the load controller.
// slave = controller side, master = surrounding system side.
interface imem_load_ctrl_if
  import imem_load_ctrl_pkg::*;
#(
  parameter int ADDR_W = PKG_ADDR_W,
  parameter int DATA_W = PKG_DATA_W
);

  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              reload;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_oob;
  logic              cpu_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W:0]   loaded_count;
  logic [1:0]        state_o;

  modport slave (
    input  ld_valid, ld_data, ld_last, reload,
    input  fetch_addr, mem_rdata,
    output ld_ready, fetch_instr, fetch_oob, cpu_stall,
    output mem_addr, mem_we, mem_wdata,
    output loaded_count, state_o
  );

  modport master (
    output ld_valid, ld_data, ld_last, reload,
    output fetch_addr, mem_rdata,
    input  ld_ready, fetch_instr, fetch_oob, cpu_stall,
    input  mem_addr, mem_we, mem_wdata,
    input  loaded_count, state_o
  );

endinterface

// File: rtl/imem_wr_seq.sv
// Write pointer and program length tracking for the loader.
// Flags the handshake that ends loading (last word or memory full).
module imem_wr_seq #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              last,
  input  logic              clear,
  output logic [ADDR_W-1:0] wptr,
  output logic [ADDR_W:0]   count,
  output logic              done
);

  logic full;

  assign full = (wptr == ADDR_W'(DEPTH - 1));
  assign done = wr && (last || full);

  // Advance on each accepted word; wptr holds at the top slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      count <= '0;
    end else if (wr) begin
      count <= count + 1'b1;
      if (!full)
        wptr <= wptr + 1'b1;
    end
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// Shares the instruction memory port between program loader and fetch.
// Stalls the CPU while loading, then serves zero-latency fetches.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int ADDR_W = PKG_ADDR_W,
  parameter int DATA_W = PKG_DATA_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input logic            clk,
  input logic            reset,
  imem_load_ctrl_if.slave bus
);

  state_t            state;
  logic              ld_ready;
  logic              cpu_stall;
  logic              hs;
  logic              clear;
  logic              done;
  logic              in_range;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   count;

  assign hs       = (state == ST_LOAD) && bus.ld_valid && ld_ready;
  assign clear    = (state == ST_RUN) && bus.reload;
  assign in_range = ({1'b0, bus.fetch_addr} < count);

  imem_wr_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_wr_seq (
    .clk   (clk),
    .reset (reset),
    .wr    (hs),
    .last  (bus.ld_last),
    .clear (clear),
    .wptr  (wptr),
    .count (count),
    .done  (done)
  );

  // FSM with registered handshake-ready and stall outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_LOAD;
      ld_ready  <= 1'b0;
      cpu_stall <= 1'b1;
    end else begin
      case (state)
        ST_LOAD: begin
          cpu_stall <= 1'b1;
          if (done) begin
            state    <= ST_DONE;
            ld_ready <= 1'b0;
          end else begin
            ld_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_RUN;
          ld_ready  <= 1'b0;
          cpu_stall <= 1'b0;
        end
        ST_RUN: begin
          if (bus.reload) begin
            state     <= ST_LOAD;
            ld_ready  <= 1'b1;
            cpu_stall <= 1'b1;
          end else begin
            ld_ready  <= 1'b0;
            cpu_stall <= 1'b0;
          end
        end
        default: begin
          state     <= ST_LOAD;
          ld_ready  <= 1'b1;
          cpu_stall <= 1'b1;
        end
      endcase
    end
  end

  // Memory port mux: loader writes in LOAD, fetch reads in RUN.
  always_comb begin
    bus.mem_we      = 1'b0;
    bus.mem_addr    = wptr;
    bus.mem_wdata   = '0;
    bus.fetch_instr = DATA_W'(NOP_INSTR);
    bus.fetch_oob   = 1'b0;
    case (state)
      ST_LOAD: begin
        if (hs) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = bus.ld_data;
        end
      end
      ST_RUN: begin
        bus.mem_addr = bus.fetch_addr;
        if (in_range)
          bus.fetch_instr = bus.mem_rdata;
        else
          bus.fetch_oob = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ld_ready     = ld_ready;
  assign bus.cpu_stall    = cpu_stall;
  assign bus.loaded_count = count;
  assign bus.state_o      = state;

endmodule
